// File: rtl/datapath_seq_if.sv
// -----------------------------------------------------------------------------
// datapath_seq_if
// Bundles the operation request, status and debug signals of datapath_seq.
//   master : controller side; drives the operation fields, start, mdata and
//            dbg_addr, and observes busy/done/result/flags/dbg_data.
//   slave  : datapath side (datapath_seq).
// Signals:
//   start               launch an operation (accepted only when idle)
//   rd, rn, rm          destination / A-source / B-source register indices
//   shift_op            00 none, 01 LSL1, 10 LSR1, 11 ASR1
//   ALU_op              00 ADD, 01 SUB (A-B), 10 AND, 11 NOT B
//   sel_A, sel_B        A forced to 0 / B taken from sximm5
//   wb_sel              11 mdata, 10 sximm8, 01 pc, 00 C
//   w_en, en_status     register writeback enable / flag update enable
//   sximm5, sximm8, pc  immediates and program counter
//   mdata               memory read data, sampled live during writeback
//   busy, done          progress; done is a one-cycle completion pulse
//   datapath_out        register C
//   Z_out, N_out, V_out status flags
//   dbg_addr, dbg_data  combinational register-file read port
// -----------------------------------------------------------------------------
interface datapath_seq_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PC_W  = 8
);
  localparam int AW = $clog2(NREGS);

  logic             start;
  logic [AW-1:0]    rd;
  logic [AW-1:0]    rn;
  logic [AW-1:0]    rm;
  logic [1:0]       shift_op;
  logic [1:0]       ALU_op;
  logic             sel_A;
  logic             sel_B;
  logic [1:0]       wb_sel;
  logic             w_en;
  logic             en_status;
  logic [WIDTH-1:0] sximm5;
  logic [WIDTH-1:0] sximm8;
  logic [PC_W-1:0]  pc;
  logic [WIDTH-1:0] mdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] datapath_out;
  logic             Z_out;
  logic             N_out;
  logic             V_out;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output start, rd, rn, rm, shift_op, ALU_op, sel_A, sel_B, wb_sel,
           w_en, en_status, sximm5, sximm8, pc, mdata, dbg_addr,
    input  busy, done, datapath_out, Z_out, N_out, V_out, dbg_data
  );

  modport slave (
    input  start, rd, rn, rm, shift_op, ALU_op, sel_A, sel_B, wb_sel,
           w_en, en_status, sximm5, sximm8, pc, mdata, dbg_addr,
    output busy, done, datapath_out, Z_out, N_out, V_out, dbg_data
  );
endinterface

// File: rtl/datapath_seq.sv
// -----------------------------------------------------------------------------
// datapath_seq
// Self-sequencing datapath: register file, A/B/C operand registers, shifter,
// ALU, Z/N/V status and writeback mux. A start pulse in IDLE captures a whole
// operation which then walks RD_A -> RD_B -> EXEC -> WB, one cycle each.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears state, regfile and datapath)
//   bus    datapath_seq_if.slave (operation fields, status, debug read)
// -----------------------------------------------------------------------------
module datapath_seq #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PC_W  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  datapath_seq_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WB} state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_A;
  logic [WIDTH-1:0] r_B;
  logic [WIDTH-1:0] r_C;
  logic             r_Z, r_N, r_V;

  // captured operation
  logic [AW-1:0]    r_rd, r_rn, r_rm;
  logic [1:0]       r_shift_op, r_alu_op, r_wb_sel;
  logic             r_sel_A, r_sel_B, r_w_en, r_en_status;
  logic [WIDTH-1:0] r_sximm5, r_sximm8;
  logic [PC_W-1:0]  r_pc;

  logic signed [WIDTH-1:0] w_val_A;
  logic signed [WIDTH-1:0] w_val_B;
  logic [WIDTH:0]          w_alu;   // {V, result}
  logic [WIDTH-1:0]        w_wb_val;

  function automatic logic [WIDTH-1:0] shift_f(input logic [WIDTH-1:0] b,
                                               input logic [1:0] op);
    logic [WIDTH-1:0] s;
    case (op)
      2'b01:   s = b << 1;
      2'b10:   s = b >> 1;
      2'b11:   s = $unsigned($signed(b) >>> 1);
      default: s = b;
    endcase
    return s;
  endfunction

  // Overflow is judged on the operand/result sign bits; carry out is dropped.
  function automatic logic [WIDTH:0] alu_f(input logic [1:0] op,
                                           input logic signed [WIDTH-1:0] a,
                                           input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] r;
    logic                    v;
    r = '0;
    v = 1'b0;
    case (op)
      2'b00: begin
        r = a + b;
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      2'b01: begin
        r = a - b;
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      2'b10:   r = a & b;
      default: r = ~b;
    endcase
    return {v, r};
  endfunction

  assign w_val_A = r_sel_A ? '0 : $signed(r_A);
  assign w_val_B = r_sel_B ? $signed(r_sximm5) : $signed(shift_f(r_B, r_shift_op));
  assign w_alu   = alu_f(r_alu_op, w_val_A, w_val_B);

  // mdata is the only source taken live; everything else was captured at start
  always_comb begin
    w_wb_val = r_C;
    case (r_wb_sel)
      2'b11:   w_wb_val = bus.mdata;
      2'b10:   w_wb_val = r_sximm8;
      2'b01:   w_wb_val = WIDTH'(r_pc);
      default: w_wb_val = r_C;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_A         <= '0;
      r_B         <= '0;
      r_C         <= '0;
      r_Z         <= 1'b0;
      r_N         <= 1'b0;
      r_V         <= 1'b0;
      r_rd        <= '0;
      r_rn        <= '0;
      r_rm        <= '0;
      r_shift_op  <= '0;
      r_alu_op    <= '0;
      r_wb_sel    <= '0;
      r_sel_A     <= 1'b0;
      r_sel_B     <= 1'b0;
      r_w_en      <= 1'b0;
      r_en_status <= 1'b0;
      r_sximm5    <= '0;
      r_sximm8    <= '0;
      r_pc        <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rd        <= bus.rd;
            r_rn        <= bus.rn;
            r_rm        <= bus.rm;
            r_shift_op  <= bus.shift_op;
            r_alu_op    <= bus.ALU_op;
            r_sel_A     <= bus.sel_A;
            r_sel_B     <= bus.sel_B;
            r_wb_sel    <= bus.wb_sel;
            r_w_en      <= bus.w_en;
            r_en_status <= bus.en_status;
            r_sximm5    <= bus.sximm5;
            r_sximm8    <= bus.sximm8;
            r_pc        <= bus.pc;
            r_busy      <= 1'b1;
            r_state     <= S_RD_A;
          end
        end
        // ---- read A ----
        S_RD_A: begin
          r_A     <= r_regs[r_rn];
          r_state <= S_RD_B;
        end
        // ---- read B ----
        S_RD_B: begin
          r_B     <= r_regs[r_rm];
          r_state <= S_EXEC;
        end
        // ---- execute ----
        S_EXEC: begin
          r_C <= w_alu[WIDTH-1:0];
          if (r_en_status) begin
            r_Z <= (w_alu[WIDTH-1:0] == '0);
            r_N <= w_alu[WIDTH-1];
            r_V <= w_alu[WIDTH];
          end
          r_state <= S_WB;
        end
        // ---- writeback ----
        S_WB: begin
          if (r_w_en) r_regs[r_rd] <= w_wb_val;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.datapath_out = r_C;
  assign bus.Z_out        = r_Z;
  assign bus.N_out        = r_N;
  assign bus.V_out        = r_V;
  assign bus.dbg_data     = r_regs[bus.dbg_addr];

endmodule

// File: tb/tb_datapath_seq.sv
`timescale 1ns/1ps
module tb_datapath_seq;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miscmp;
  int   lat;
  int   lat2;
  int   ndone;
  logic [15:0] v;

  datapath_seq_if #(.WIDTH(16), .NREGS(8), .PC_W(8)) bus ();

  datapath_seq #(.WIDTH(16), .NREGS(8), .PC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clr_fields();
    bus.start     = 1'b0;
    bus.rd        = '0;
    bus.rn        = '0;
    bus.rm        = '0;
    bus.shift_op  = 2'b00;
    bus.ALU_op    = 2'b00;
    bus.sel_A     = 1'b0;
    bus.sel_B     = 1'b0;
    bus.wb_sel    = 2'b00;
    bus.w_en      = 1'b0;
    bus.en_status = 1'b0;
    bus.sximm5    = '0;
    bus.sximm8    = '0;
    bus.pc        = '0;
    bus.mdata     = 16'hDEAD;
    bus.dbg_addr  = '0;
  endtask

  // Launch the operation currently on the bus and wait (bounded) for done.
  // lat = clock edges from the accepting edge to the edge that raises done.
  task automatic go(input bit b2b, input bit mdata_wb, input bit poke, output int l);
    if (!b2b) begin
      @(posedge clk); #1;
    end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    l = 0;
    while (!bus.done && l < 10) begin
      if (mdata_wb && l == 3) bus.mdata = 16'h1234;
      if (poke) bus.start = (l == 1);
      @(posedge clk); #1;
      l++;
    end
    bus.start = 1'b0;
    bus.mdata = 16'hDEAD;
  endtask

  task automatic rdreg(input int a, output logic [15:0] val);
    bus.dbg_addr = a[2:0];
    #1;
    val = bus.dbg_data;
  endtask

  task automatic load(input int r, input logic [15:0] val);
    int l;
    clr_fields();
    bus.rd     = r[2:0];
    bus.wb_sel = 2'b10;
    bus.sximm8 = val;
    bus.w_en   = 1'b1;
    go(1'b0, 1'b0, 1'b0, l);
    chk("load_lat", l, 4);
  endtask

  task automatic op(input int rd, input int rn, input int rm, input logic [1:0] alu,
                    input logic [1:0] sh, input bit sa, input bit wen, input bit ens);
    clr_fields();
    bus.rd        = rd[2:0];
    bus.rn        = rn[2:0];
    bus.rm        = rm[2:0];
    bus.ALU_op    = alu;
    bus.shift_op  = sh;
    bus.sel_A     = sa;
    bus.w_en      = wen;
    bus.en_status = ens;
  endtask

  initial begin
    n_vec = 0;
    n_miscmp = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    clr_fields();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_C", bus.datapath_out, 0);
    chk("rst_flags", {bus.Z_out, bus.N_out, bus.V_out}, 0);
    rst_n = 1'b1;

    // Put state into the datapath, then reset mid-EXEC
    load(0, 16'h0005);
    load(1, 16'h8000);
    op(4, 0, 1, 2'b00, 2'b00, 0, 1, 1);
    go(1'b0, 1'b0, 1'b0, lat);
    chk("pre_rst_C", bus.datapath_out, 16'h8005);
    rdreg(4, v);
    chk("pre_rst_R4", v, 16'h8005);
    op(5, 0, 1, 2'b00, 2'b00, 0, 1, 1);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;       // RD_A
    bus.start = 1'b0;
    @(posedge clk); #1;       // RD_B
    @(posedge clk); #1;       // EXEC
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_C", bus.datapath_out, 0);
    chk("midrst_flags", {bus.Z_out, bus.N_out, bus.V_out}, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rdreg(i, v);
      chk($sformatf("midrst_R%0d", i), v, 0);
    end
    ndone = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    chk("midrst_idle_busy", bus.busy, 0);
    rdreg(5, v);
    chk("midrst_R5", v, 0);

    // Basic ADD: R2 = R0 + R1
    load(0, 16'h0007);
    load(1, 16'h0002);
    op(2, 0, 1, 2'b00, 2'b00, 0, 1, 1);
    go(1'b0, 1'b0, 1'b0, lat);
    chk("add_lat", lat, 4);
    chk("add_done", bus.done, 1);
    chk("add_C", bus.datapath_out, 16'h0009);
    chk("add_flags", {bus.Z_out, bus.N_out, bus.V_out}, 3'b000);
    rdreg(2, v);
    chk("add_R2", v, 16'h0009);
    @(posedge clk); #1;
    chk("done_pulse_end", bus.done, 0);

    // Signed overflow and zero result
    load(0, 16'h7FFF);
    load(1, 16'h0001);
    op(3, 0, 1, 2'b00, 2'b00, 0, 1, 1);
    go(1'b0, 1'b0, 1'b0, lat);
    chk("ovf_C", bus.datapath_out, 16'h8000);
    chk("ovf_flags", {bus.Z_out, bus.N_out, bus.V_out}, 3'b011);
    op(3, 1, 1, 2'b01, 2'b00, 0, 1, 1);
    go(1'b0, 1'b0, 1'b0, lat);
    chk("sub0_C", bus.datapath_out, 16'h0000);
    chk("sub0_flags", {bus.Z_out, bus.N_out, bus.V_out}, 3'b100);

    // Shifter with A forced to 0; flags must hold (Z=1 from the SUB)
    load(1, 16'h8001);
    op(0, 0, 1, 2'b00, 2'b01, 1, 0, 0);
    go(1'b0, 1'b0, 1'b0, lat);
    chk("lsl_C", bus.datapath_out, 16'h0002);
    chk("lsl_flags_hold", {bus.Z_out, bus.N_out, bus.V_out}, 3'b100);
    op(0, 0, 1, 2'b00, 2'b10, 1, 0, 0);
    go(1'b0, 1'b0, 1'b0, lat);
    chk("lsr_C", bus.datapath_out, 16'h4000);
    op(0, 0, 1, 2'b00, 2'b11, 1, 0, 0);
    go(1'b0, 1'b0, 1'b0, lat);
    chk("asr_C", bus.datapath_out, 16'hC000);
    chk("asr_flags_hold", {bus.Z_out, bus.N_out, bus.V_out}, 3'b100);

    // Same register as source and destination, writeback from C, carry dropped
    op(1, 1, 1, 2'b00, 2'b00, 0, 1, 1);
    go(1'b0, 1'b0, 1'b0, lat);
    chk("selfadd_C", bus.datapath_out, 16'h0002);
    chk("selfadd_flags", {bus.Z_out, bus.N_out, bus.V_out}, 3'b001);
    rdreg(1, v);
    chk("selfadd_R1", v, 16'h0002);

    // AND with immediate B (R0 = 0x7FFF)
    op(0, 0, 0, 2'b10, 2'b00, 0, 0, 1);
    bus.sel_B  = 1'b1;
    bus.sximm5 = 16'h00F0;
    go(1'b0, 1'b0, 1'b0, lat);
    chk("and_C", bus.datapath_out, 16'h00F0);
    chk("and_flags", {bus.Z_out, bus.N_out, bus.V_out}, 3'b000);

    // Writeback sources
    op(6, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    bus.wb_sel = 2'b01;
    bus.pc     = 8'hA5;
    go(1'b0, 1'b0, 1'b0, lat);
    rdreg(6, v);
    chk("wb_pc_R6", v, 16'h00A5);
    op(7, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    bus.wb_sel = 2'b11;
    go(1'b0, 1'b1, 1'b0, lat);
    rdreg(7, v);
    chk("wb_mdata_R7", v, 16'h1234);
    op(6, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    bus.wb_sel = 2'b10;
    bus.sximm8 = 16'h5555;
    go(1'b0, 1'b0, 1'b0, lat);
    rdreg(6, v);
    chk("wen0_R6", v, 16'h00A5);

    // NOT B on R6
    op(0, 0, 6, 2'b11, 2'b00, 0, 0, 1);
    go(1'b0, 1'b0, 1'b0, lat);
    chk("not_C", bus.datapath_out, 16'hFF5A);
    chk("not_flags", {bus.Z_out, bus.N_out, bus.V_out}, 3'b010);

    // Back-to-back: second start issued in the done cycle
    op(3, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    bus.wb_sel = 2'b10;
    bus.sximm8 = 16'h1111;
    go(1'b0, 1'b0, 1'b0, lat);
    chk("b2b_lat1", lat, 4);
    op(4, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    bus.wb_sel = 2'b10;
    bus.sximm8 = 16'h2222;
    go(1'b1, 1'b0, 1'b0, lat2);
    chk("b2b_lat2", lat2, 4);
    rdreg(3, v);
    chk("b2b_R3", v, 16'h1111);
    rdreg(4, v);
    chk("b2b_R4", v, 16'h2222);

    // start during busy is ignored
    op(5, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    bus.wb_sel = 2'b10;
    bus.sximm8 = 16'h3333;
    go(1'b0, 1'b0, 1'b1, lat);
    chk("poke_lat", lat, 4);
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("poke_no_extra_done", ndone, 0);
    chk("poke_busy", bus.busy, 0);
    rdreg(5, v);
    chk("poke_R5", v, 16'h3333);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
